// File: rtl/vdp_scanout.sv
// 640x480 scan-out timing with a 160x120 8 bpp framebuffer fetched from shared RAM
// through a 16-byte FIFO; each fetched byte paints a 4x4 dot block.
module vdp_scanout #(
  parameter logic [15:0] FB_BASE = 16'h2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_grant,
  output logic [15:0] vdp_addr,
  input  logic [7:0]  ram_data,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        vblank,
  output logic        underflow
);

  localparam logic [9:0] H_LAST     = 10'd799;
  localparam logic [9:0] V_LAST     = 10'd524;
  localparam logic [9:0] H_ACTIVE   = 10'd640;
  localparam logic [9:0] V_ACTIVE   = 10'd480;
  localparam logic [9:0] HS_START   = 10'd656;
  localparam logic [9:0] HS_END     = 10'd751;
  localparam logic [9:0] VS_START   = 10'd490;
  localparam logic [9:0] VS_END     = 10'd491;
  localparam logic [7:0] LINE_BYTES = 8'd160;
  localparam logic [4:0] FIFO_DEPTH = 5'd16;

  logic [9:0]  h, v, t_line;
  logic [7:0]  fifo_mem [16];
  logic [3:0]  rd_ptr, wr_ptr;
  logic [4:0]  occ;
  logic        in_flight;
  logic [7:0]  fetch_cnt;
  logic [15:0] fetch_addr, addr_q, line_base;
  logic [7:0]  pix_q, pix_byte;
  logic        line_start, active, pop_slot, pop, push, issue;

  always_comb begin
    line_start = (h == HS_START);
    t_line     = (v == V_LAST) ? '0 : v + 10'd1;
    // (t>>2)*160 as two shifted adds, 16-bit modulo
    line_base  = FB_BASE + ({8'd0, t_line[9:2]} << 7) + ({8'd0, t_line[9:2]} << 5);
    active     = (h < H_ACTIVE) && (v < V_ACTIVE);
    pop_slot   = active && (h[1:0] == 2'd0);
    pop        = pop_slot && (occ != '0);
    push       = in_flight && !line_start;
    issue      = bus_grant && !line_start && (fetch_cnt < LINE_BYTES) &&
                 ((occ + {4'd0, in_flight}) < FIFO_DEPTH);
    vdp_addr   = issue ? fetch_addr : addr_q;
    pix_byte   = pix_q;
    if (pop_slot) pix_byte = pop ? fifo_mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h <= '0;
      v <= V_LAST;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // A line start cancels any read issued on the previous clock as well as the FIFO contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt  <= LINE_BYTES;
      fetch_addr <= FB_BASE;
      addr_q     <= FB_BASE;
      in_flight  <= 1'b0;
    end else begin
      in_flight <= issue;
      if (line_start) begin
        fetch_cnt  <= (t_line < V_ACTIVE) ? '0 : LINE_BYTES;
        fetch_addr <= line_base;
      end else if (issue) begin
        fetch_cnt  <= fetch_cnt + 8'd1;
        fetch_addr <= fetch_addr + 16'd1;
        addr_q     <= fetch_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (line_start) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 4'd1;
      if (pop)  rd_ptr <= rd_ptr + 4'd1;
      occ <= occ + {4'd0, push} - {4'd0, pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r         <= '0;
      g         <= '0;
      b         <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      vblank    <= 1'b1;
      underflow <= 1'b0;
      pix_q     <= '0;
    end else begin
      hsync  <= !((h >= HS_START) && (h <= HS_END));
      vsync  <= !((v >= VS_START) && (v <= VS_END));
      vblank <= (v >= V_ACTIVE);
      if (pop_slot) pix_q <= pix_byte;
      if (pop_slot && !pop) underflow <= 1'b1;
      if (active) begin
        r <= {pix_byte[7:5], pix_byte[7]};
        g <= {pix_byte[4:2], pix_byte[4]};
        b <= {pix_byte[1:0], pix_byte[1:0]};
      end else begin
        r <= '0;
        g <= '0;
        b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vdp_scanout.sv
// Bench for vdp_scanout: per-dot model of timing and colour, read-address scoreboard,
// constant dot/line tables, grant starvation and a mid-line asynchronous reset.
module tb_vdp_scanout;

  localparam logic [15:0] FB_BASE = 16'h2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_grant;
  logic [15:0] vdp_addr;
  logic [7:0]  ram_data = '0;
  logic [3:0]  r, g, b;
  logic        hsync, vsync, vblank, underflow;

  vdp_scanout #(.FB_BASE(FB_BASE)) dut (
    .clk(clk), .reset(reset), .bus_grant(bus_grant), .vdp_addr(vdp_addr),
    .ram_data(ram_data), .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync),
    .vblank(vblank), .underflow(underflow)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [65536];
  always @(posedge clk) ram_data <= mem[vdp_addr];

  typedef struct { int unsigned h; int unsigned v; logic [11:0] rgb; } dot_vec_t;
  typedef struct { int unsigned t; logic [15:0] base; } line_vec_t;
  dot_vec_t  dot_tab[$];
  line_vec_t line_tab[$];

  int unsigned vectors = 0, miscompares = 0;
  int unsigned n, phase, cur_t, idx, hs_low;
  bit          have_win;
  logic [15:0] last_addr;

  localparam int unsigned STARVE_LINE = 10;
  localparam int unsigned UF_POS      = 800 + STARVE_LINE * 800 + 64;

  function automatic int unsigned pos_h(input int unsigned p);
    return p % 800;
  endfunction

  function automatic int unsigned pos_v(input int unsigned p);
    return (524 + p / 800) % 525;
  endfunction

  function automatic logic [11:0] colour(input logic [7:0] px);
    int unsigned rr, gg, bb;
    rr = px / 32;
    gg = (px / 4) % 8;
    bb = px % 4;
    return {4'(rr * 2 + rr / 4), 4'(gg * 2 + gg / 4), 4'(bb * 5)};
  endfunction

  function automatic logic [11:0] exp_rgb(input int unsigned h, input int unsigned v);
    if (h >= 640 || v >= 480) return '0;
    if (phase == 1 && v == STARVE_LINE && h >= 64) return '0;
    return colour(mem[16'(FB_BASE + (v / 4) * 160 + h / 4)]);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic grant_for(input int unsigned h, input int unsigned v, input int unsigned p);
    if (phase == 2) return $urandom_range(0, 3) != 0;
    if (v == 524 || v < 4) return 1'b1;
    if (v < STARVE_LINE) return (p % 16) < 8;
    if (v == STARVE_LINE) return h >= 640;
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic run_cycle();
    int unsigned oh, ov, sh, sv;
    logic [15:0] exp_a, want_a;
    logic [11:0] rgb;
    @(negedge clk);
    n++;
    oh  = pos_h(n - 1);
    ov  = pos_v(n - 1);
    rgb = exp_rgb(oh, ov);
    check($sformatf("dot(h=%0d,v=%0d) {rgb,hs,vs,vb,uf}", oh, ov),
          {r, g, b, hsync, vsync, vblank, underflow},
          {rgb, !(oh >= 656 && oh <= 751), !(ov == 490 || ov == 491), ov >= 480,
           (phase == 1) && ((n - 1) >= UF_POS)});
    if (phase == 1)
      foreach (dot_tab[k])
        if (dot_tab[k].h == oh && dot_tab[k].v == ov)
          check($sformatf("dot_table(h=%0d,v=%0d)", oh, ov), {r, g, b}, dot_tab[k].rgb);
    if (!hsync) hs_low++;
    if (oh == 799) begin
      check($sformatf("hsync_low_count(v=%0d)", ov), hs_low, 96);
      hs_low = 0;
    end

    sh = pos_h(n);
    sv = pos_v(n);
    bus_grant = grant_for(sh, sv, n);
    #1;
    if (sh == 656) begin
      cur_t    = (sv == 524) ? 0 : sv + 1;
      idx      = 0;
      have_win = 1'b1;
    end else if (vdp_addr !== last_addr) begin
      exp_a = 16'(FB_BASE + (cur_t / 4) * 160 + idx);
      // After reset the held address equals the first fetch address, so that read is not visible.
      if (idx == 0 && last_addr == exp_a) begin
        exp_a = exp_a + 16'd1;
        idx   = 1;
      end
      want_a = (have_win && cur_t < 480 && idx < 160) ? exp_a : last_addr;
      check($sformatf("read_addr(t=%0d,i=%0d)", cur_t, idx), vdp_addr, want_a);
      if (idx == 0)
        foreach (line_tab[k])
          if (line_tab[k].t == cur_t)
            check($sformatf("line_base(t=%0d)", cur_t), vdp_addr, line_tab[k].base);
      idx++;
      last_addr = vdp_addr;
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_outputs"}, {r, g, b, hsync, vsync, vblank, underflow}, {12'h000, 4'b1110});
    check({name, "_addr"}, vdp_addr, FB_BASE);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a);
    dot_tab.push_back('{0,   0,  12'h000});
    dot_tab.push_back('{3,   0,  12'h000});
    dot_tab.push_back('{4,   0,  12'h005});
    dot_tab.push_back('{7,   0,  12'h005});
    dot_tab.push_back('{8,   0,  12'h00A});
    dot_tab.push_back('{636, 0,  12'h9FF});
    dot_tab.push_back('{0,   4,  12'hB00});
    dot_tab.push_back('{100, 7,  12'hBD5});
    dot_tab.push_back('{640, 5,  12'h000});
    dot_tab.push_back('{320, 9,  12'h990});
    dot_tab.push_back('{60,  10, 12'h46F});
    dot_tab.push_back('{64,  10, 12'h000});
    dot_tab.push_back('{100, 10, 12'h000});
    dot_tab.push_back('{64,  11, 12'h490});
    line_tab.push_back('{1,  16'h2000});
    line_tab.push_back('{3,  16'h2000});
    line_tab.push_back('{4,  16'h20A0});
    line_tab.push_back('{7,  16'h20A0});
    line_tab.push_back('{8,  16'h2140});
    line_tab.push_back('{12, 16'h21E0});
    line_tab.push_back('{16, 16'h2280});
    line_tab.push_back('{19, 16'h2280});

    reset = 1'b0;
    bus_grant = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset_state("reset");
    end

    @(negedge clk);
    reset = 1'b1;
    phase = 1; n = 0; hs_low = 0; have_win = 1'b0; last_addr = FB_BASE;
    while (n < 17100) run_cycle();

    // State is now h=300 of line 20: reset must act before any clock edge.
    reset = 1'b0;
    #1;
    check_reset_state("async_reset");
    repeat (2) begin
      @(negedge clk);
      check_reset_state("held_reset");
    end

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    reset = 1'b1;
    phase = 2; n = 0; hs_low = 0; have_win = 1'b0; last_addr = FB_BASE;
    while (n < 10400) run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
